// File: rtl/rx_pkg.sv
// Shared constants, state type and CRC32 byte step for the GMII receive path.
package rx_pkg;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    // Reflected CRC32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC32 accumulator with synchronous clear and enable.
module crc32_d8
    import rx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    always_comb begin
        w_crc_nxt = crc32_byte(r_crc, i_data);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/rx_gmii_framer.sv
// GMII receive framer: finds preamble/SFD, strips preamble/SFD/FCS and
// reports a per-frame CRC/length/error verdict for the downstream voter.
module rx_gmii_framer
    import rx_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned PRE_MIN = 2
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_enable,
    input  logic        rx_error,
    output logic        sfd_wait,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        frame_done,
    output logic        frame_good,
    output logic [10:0] frame_len,
    output logic [15:0] bad_cnt
);

    localparam int unsigned LEN_W = 11;
    localparam logic [LEN_W-1:0] LEN_SAT = '1;
    localparam logic [LEN_W-1:0] MIN_C   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_C   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_P1  = LEN_W'(MAX_LEN + 1);
    localparam logic [2:0]       PRE_C   = 3'(PRE_MIN);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [2:0]       r_pre_cnt;
    logic [2:0]       w_pre_nxt;
    logic             r_from_data;
    logic             w_from_data_nxt;
    logic [3:0][7:0]  r_dly;
    logic [2:0]       r_dly_cnt;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_cnt_en;
    logic             w_over;
    logic             r_err;
    logic             r_sof_seen;
    logic             w_push;
    logic             w_end;
    logic             w_good;
    logic             w_crc_clr;
    logic             w_crc_en;
    logic [31:0]      w_crc;

    crc32_d8 u_crc (
        .i_clk   (rx_clk),
        .i_rst_n (reset),
        .i_clr   (w_crc_clr),
        .i_en    (w_crc_en),
        .i_data  (rx_data),
        .o_crc   (w_crc)
    );

    // Byte counter keeps running through an overlength DROP so frame_len reports the full burst.
    always_comb begin
        w_crc_clr = (r_state != DATA);
        w_crc_en  = (r_state == DATA) && rx_enable;
        w_cnt_en  = rx_enable && ((r_state == DATA) || ((r_state == DROP) && r_from_data));
        w_cnt_inc = (r_byte_cnt == LEN_SAT) ? r_byte_cnt : r_byte_cnt + 11'd1;
        w_over    = (w_cnt_inc == MAX_P1);
        w_good    = (w_crc == CRC_RESIDUE) && !r_err
                    && (r_byte_cnt >= MIN_C) && (r_byte_cnt <= MAX_C);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pre_nxt       = r_pre_cnt;
        w_from_data_nxt = r_from_data;
        w_push          = 1'b0;
        w_end           = 1'b0;
        case (r_state)
            HUNT: begin
                w_from_data_nxt = 1'b0;
                if (!rx_enable) begin
                    w_pre_nxt = '0;
                end else if (rx_data == PREAMBLE) begin
                    if (r_pre_cnt != 3'd7) begin
                        w_pre_nxt = r_pre_cnt + 3'd1;
                    end
                end else if ((rx_data == SFD) && (r_pre_cnt >= PRE_C)) begin
                    w_state_nxt = DATA;
                    w_pre_nxt   = '0;
                end else begin
                    w_state_nxt = DROP;
                    w_pre_nxt   = '0;
                end
            end
            DATA: begin
                if (!rx_enable) begin
                    w_end       = 1'b1;
                    w_state_nxt = HUNT;
                end else if (w_over) begin
                    w_state_nxt     = DROP;
                    w_from_data_nxt = 1'b1;
                end else if (r_dly_cnt == 3'd4) begin
                    w_push = 1'b1;
                end
            end
            DROP: begin
                if (!rx_enable) begin
                    w_end           = r_from_data;
                    w_state_nxt     = HUNT;
                    w_from_data_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= HUNT;
            r_pre_cnt   <= '0;
            r_from_data <= 1'b0;
            sfd_wait    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_nxt;
            r_from_data <= w_from_data_nxt;
            sfd_wait    <= (w_state_nxt != DATA);
        end
    end

    // FCS stays hidden because a byte is only released once four newer bytes are behind it.
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= '0;
            bad_cnt    <= '0;
            r_dly      <= '0;
            r_dly_cnt  <= '0;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
            r_sof_seen <= 1'b0;
        end else begin
            out_valid  <= w_push;
            out_data   <= w_push ? r_dly[3] : 8'h00;
            out_sof    <= w_push && !r_sof_seen;
            frame_done <= w_end;
            frame_good <= w_end && w_good;
            frame_len  <= w_end ? r_byte_cnt : '0;
            if (w_end && !w_good && (bad_cnt != 16'hFFFF)) begin
                bad_cnt <= bad_cnt + 16'd1;
            end
            if (r_state == HUNT) begin
                r_dly      <= '0;
                r_dly_cnt  <= '0;
                r_byte_cnt <= '0;
                r_err      <= 1'b0;
                r_sof_seen <= 1'b0;
            end else if (w_cnt_en) begin
                r_byte_cnt <= w_cnt_inc;
                if (r_state == DATA) begin
                    r_err <= r_err || rx_error || w_over;
                    r_dly <= {r_dly[2:0], rx_data};
                    if (r_dly_cnt != 3'd4) begin
                        r_dly_cnt <= r_dly_cnt + 3'd1;
                    end
                end
                if (w_push) begin
                    r_sof_seen <= 1'b1;
                end
            end
        end
    end

endmodule
